// File: rtl/id_stage_if.sv
// Bundles the fetch, writeback and decode-result signals of the RV32I decode stage.
// The slave modport is the decode stage itself; the master modport is its environment.
interface id_stage_if;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        illegal;

    modport master (
        output if_instr, if_pc, stall, flush, wb_we, wb_rd, wb_data,
        input  id_valid, id_pc, id_instr, rs1_addr, rs2_addr, rd_addr, opcode, funct3, funct7,
        input  rs1_data, rs2_data, imm, reg_write, mem_read, mem_write, branch, jump, alu_src,
        input  illegal
    );

    modport slave (
        input  if_instr, if_pc, stall, flush, wb_we, wb_rd, wb_data,
        output id_valid, id_pc, id_instr, rs1_addr, rs2_addr, rd_addr, opcode, funct3, funct7,
        output rs1_data, rs2_data, imm, reg_write, mem_read, mem_write, branch, jump, alu_src,
        output illegal
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID pipeline register, 32x32 register file with write-first bypass,
// and combinational field/immediate/control decode.
module id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic       clk,
    input logic       rst_n,
    id_stage_if.slave bus
);
    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];

    // Flush squashes to the reset image and takes priority over stall.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = RESET_PC;
        end else if (!bus.stall) begin
            valid_d = 1'b1;
            instr_d = bus.if_instr;
            pc_d    = bus.if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    // Writeback is independent of stall/flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (bus.wb_we && (bus.wb_rd != 5'd0)) begin
            rf_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    logic [4:0] rs1, rs2;
    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];

    always_comb begin
        bus.rs1_data = rf_q[rs1];
        bus.rs2_data = rf_q[rs2];
        if (bus.wb_we && (bus.wb_rd == rs1)) bus.rs1_data = bus.wb_data;
        if (bus.wb_we && (bus.wb_rd == rs2)) bus.rs2_data = bus.wb_data;
        if (rs1 == 5'd0) bus.rs1_data = '0;
        if (rs2 == 5'd0) bus.rs2_data = '0;
    end

    assign bus.id_valid = valid_q;
    assign bus.id_pc    = pc_q;
    assign bus.id_instr = instr_q;
    assign bus.rs1_addr = rs1;
    assign bus.rs2_addr = rs2;
    assign bus.rd_addr  = instr_q[11:7];
    assign bus.opcode   = instr_q[6:0];
    assign bus.funct3   = instr_q[14:12];
    assign bus.funct7   = instr_q[31:25];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u = {instr_q[31:12], 12'b0};
    assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21],
                    1'b0};

    // ctrl = {reg_write, mem_read, mem_write, branch, jump, alu_src}
    logic [5:0] ctrl;
    logic       ill;

    always_comb begin
        ctrl    = 6'b000000;
        ill     = 1'b0;
        bus.imm = '0;
        case (instr_q[6:0])
            OpR:     ctrl = 6'b100000;
            OpImm:   begin ctrl = 6'b100001; bus.imm = imm_i; end
            OpLoad:  begin ctrl = 6'b110001; bus.imm = imm_i; end
            OpStore: begin ctrl = 6'b001001; bus.imm = imm_s; end
            OpBr:    begin ctrl = 6'b000100; bus.imm = imm_b; end
            OpJal:   begin ctrl = 6'b100010; bus.imm = imm_j; end
            OpJalr:  begin ctrl = 6'b100011; bus.imm = imm_i; end
            OpLui:   begin ctrl = 6'b100001; bus.imm = imm_u; end
            OpAuipc: begin ctrl = 6'b100001; bus.imm = imm_u; end
            default: ill = 1'b1;
        endcase
        if (!valid_q) begin
            ctrl = 6'b000000;
            ill  = 1'b0;
        end
    end

    assign {bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump, bus.alu_src} = ctrl;
    assign bus.illegal = ill;
endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: reset, decode formats, bypass, x0, stall/flush,
// illegal opcode and mid-stream reset.
module tb_id_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ctrl_obs();
        return {bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump, bus.alu_src};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.id_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.id_valid);
        end
        n_checks++;
        if (bus.id_instr !== 32'h0000_0013) begin
            n_fail++; $display("FAIL reset_instr: got %h want 00000013", bus.id_instr);
        end
        n_checks++;
        if (bus.id_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h want 00000000", bus.id_pc);
        end
        n_checks++;
        if ({ctrl_obs(), bus.illegal} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {ctrl_obs(), bus.illegal});
        end
        n_checks++;
        if ({bus.rs1_data, bus.rs2_data} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rsdata: got %h %h want 0 0", bus.rs1_data, bus.rs2_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_decode();
        bus.if_instr = 32'h0050_0093;
        bus.if_pc    = 32'h0000_0100;
        tick();
        n_checks++;
        if ({bus.id_valid, bus.illegal} !== 2'b10) begin
            n_fail++; $display("FAIL basic_valid: got valid=%0b illegal=%0b want 1 0",
                               bus.id_valid, bus.illegal);
        end
        n_checks++;
        if (bus.id_pc !== 32'h100) begin
            n_fail++; $display("FAIL basic_pc: got %h want 00000100", bus.id_pc);
        end
        n_checks++;
        if ({bus.rd_addr, bus.rs1_addr, bus.opcode, bus.funct3} !== {5'd1, 5'd0, 7'h13, 3'd0}) begin
            n_fail++; $display("FAIL basic_fields: got rd=%0d rs1=%0d op=%h f3=%0d want 1 0 13 0",
                               bus.rd_addr, bus.rs1_addr, bus.opcode, bus.funct3);
        end
        n_checks++;
        if (bus.imm !== 32'd5) begin
            n_fail++; $display("FAIL basic_imm: got %h want 00000005", bus.imm);
        end
        n_checks++;
        if (ctrl_obs() !== 6'b100001) begin
            n_fail++; $display("FAIL basic_ctrl: got %b want 100001", ctrl_obs());
        end
    endtask

    task automatic test_x0_write();
        // addi x1,x0,5 is still held, so rs1 reads x0
        bus.stall   = 1'b1;
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 5'd0;
        bus.wb_data = 32'h1234_5678;
        #1;
        n_checks++;
        if (bus.rs1_data !== 32'h0) begin
            n_fail++; $display("FAIL x0_bypass: got %h want 00000000", bus.rs1_data);
        end
        tick();
        bus.wb_we = 1'b0;
        #1;
        n_checks++;
        if (bus.rs1_data !== 32'h0) begin
            n_fail++; $display("FAIL x0_after_write: got %h want 00000000", bus.rs1_data);
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_bypass();
        bus.if_instr = 32'h0021_01B3;
        bus.if_pc    = 32'h0000_0104;
        tick();
        n_checks++;
        if ({bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.rs1_data} !== {5'd2, 5'd2, 5'd3, 32'h0})
        begin
            n_fail++; $display("FAIL bypass_pre: got rs1=%0d rs2=%0d rd=%0d d1=%h want 2 2 3 0",
                               bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.rs1_data);
        end
        bus.stall   = 1'b1;
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 5'd2;
        bus.wb_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({bus.rs1_data, bus.rs2_data} !== {2{32'hDEAD_BEEF}}) begin
            n_fail++; $display("FAIL bypass_same_cycle: got %h %h want deadbeef deadbeef",
                               bus.rs1_data, bus.rs2_data);
        end
        tick();
        bus.wb_we   = 1'b0;
        bus.wb_data = 32'h0;
        #1;
        n_checks++;
        if ({bus.rs1_data, bus.rs2_data} !== {2{32'hDEAD_BEEF}}) begin
            n_fail++; $display("FAIL bypass_after_write: got %h %h want deadbeef deadbeef",
                               bus.rs1_data, bus.rs2_data);
        end
        n_checks++;
        if (bus.id_instr !== 32'h0021_01B3) begin
            n_fail++; $display("FAIL bypass_stall_hold: got %h want 002101b3", bus.id_instr);
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_branch();
        bus.if_instr = 32'hFE00_0EE3;
        bus.if_pc    = 32'h0000_0108;
        tick();
        n_checks++;
        if (bus.imm !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL branch_imm: got %h want fffffffc", bus.imm);
        end
        n_checks++;
        if (ctrl_obs() !== 6'b000100) begin
            n_fail++; $display("FAIL branch_ctrl: got %b want 000100", ctrl_obs());
        end
    endtask

    task automatic test_formats();
        logic [31:0] instrs [7];
        logic [31:0] imms   [7];
        logic [5:0]  ctrls  [7];
        instrs[0] = 32'hFE20_AC23; imms[0] = 32'hFFFF_FFF8; ctrls[0] = 6'b001001; // sw x2,-8(x1)
        instrs[1] = 32'h0040_A183; imms[1] = 32'h0000_0004; ctrls[1] = 6'b110001; // lw x3,4(x1)
        instrs[2] = 32'h1234_52B7; imms[2] = 32'h1234_5000; ctrls[2] = 6'b100001; // lui
        instrs[3] = 32'h0080_00EF; imms[3] = 32'h0000_0008; ctrls[3] = 6'b100010; // jal x1,8
        instrs[4] = 32'h0000_8067; imms[4] = 32'h0000_0000; ctrls[4] = 6'b100011; // jalr
        instrs[5] = 32'hFFFF_F097; imms[5] = 32'hFFFF_F000; ctrls[5] = 6'b100001; // auipc
        instrs[6] = 32'h0021_01B3; imms[6] = 32'h0000_0000; ctrls[6] = 6'b100000; // add
        for (int i = 0; i < 7; i++) begin
            bus.if_instr = instrs[i];
            bus.if_pc    = 32'h400 + 32'(4 * i);
            tick();
            n_checks++;
            if ({bus.imm, ctrl_obs(), bus.illegal} !== {imms[i], ctrls[i], 1'b0}) begin
                n_fail++; $display("FAIL format_%0d: got imm=%h ctrl=%b ill=%0b want %h %b 0",
                                   i, bus.imm, ctrl_obs(), bus.illegal, imms[i], ctrls[i]);
            end
        end
    endtask

    task automatic test_stall_flush();
        bus.if_instr = 32'h0050_0093;
        bus.if_pc    = 32'h0000_0200;
        tick();
        bus.stall    = 1'b1;
        bus.if_instr = 32'h0040_A183;
        bus.if_pc    = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bus.id_pc, bus.id_instr, bus.id_valid} !== {32'h200, 32'h0050_0093, 1'b1}) begin
                n_fail++; $display("FAIL stall_hold_%0d: got pc=%h instr=%h v=%0b want 200 00500093 1",
                                   i, bus.id_pc, bus.id_instr, bus.id_valid);
            end
        end
        // flush beats stall; writeback still lands during the flush
        bus.flush   = 1'b1;
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 5'd5;
        bus.wb_data = 32'h0000_A5A5;
        tick();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        bus.wb_we = 1'b0;
        n_checks++;
        if ({bus.id_valid, bus.id_instr, bus.id_pc} !== {1'b0, 32'h0000_0013, 32'h0}) begin
            n_fail++; $display("FAIL flush_state: got v=%0b instr=%h pc=%h want 0 00000013 0",
                               bus.id_valid, bus.id_instr, bus.id_pc);
        end
        n_checks++;
        if ({ctrl_obs(), bus.illegal} !== 7'b0) begin
            n_fail++; $display("FAIL flush_ctrl: got %b want 0000000", {ctrl_obs(), bus.illegal});
        end
        bus.if_instr = 32'h0052_8333; // add x6,x5,x5
        tick();
        n_checks++;
        if (bus.rs1_data !== 32'h0000_A5A5) begin
            n_fail++; $display("FAIL write_during_flush: got %h want 0000a5a5", bus.rs1_data);
        end
    endtask

    task automatic test_illegal();
        bus.if_instr = 32'hFFFF_FFFF;
        tick();
        n_checks++;
        if ({bus.id_valid, bus.illegal, ctrl_obs(), bus.imm} !== {1'b1, 1'b1, 6'b0, 32'h0}) begin
            n_fail++; $display("FAIL illegal: got v=%0b ill=%0b ctrl=%b imm=%h want 1 1 000000 0",
                               bus.id_valid, bus.illegal, ctrl_obs(), bus.imm);
        end
    endtask

    task automatic test_reset_midstream();
        bus.if_instr = 32'h0021_01B3;
        tick();
        n_checks++;
        if (bus.rs1_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL midreset_pre: got %h want deadbeef", bus.rs1_data);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({bus.id_valid, bus.id_instr} !== {1'b0, 32'h0000_0013}) begin
            n_fail++; $display("FAIL midreset_ifid: got v=%0b instr=%h want 0 00000013",
                               bus.id_valid, bus.id_instr);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.rs1_data, bus.rs2_data} !== 64'h0) begin
            n_fail++; $display("FAIL midreset_rf: got %h %h want 0 0", bus.rs1_data, bus.rs2_data);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.if_instr = 32'h0;
        bus.if_pc    = 32'h0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'h0;
        test_reset();
        test_basic_decode();
        test_x0_write();
        test_bypass();
        test_branch();
        test_formats();
        test_stall_flush();
        test_illegal();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
